cube_loader: RTL

CUBE_LOADER -- requirements
Module: cube_loader

---
 rtl/cube_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/cube_loader.sv
// rtl/cube_loader.sv - collects NODES values into one frame and hands it to the sorter.
// Optional short-frame padding via `define CUBE_LOADER_PAD_EN.
module cube_loader #(
  parameter int DATA_W = 16,
  parameter int NODES  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [NODES*DATA_W-1:0] frame_data,
  output logic [4:0]              frame_len,
  output logic [7:0]              frame_cnt
);

  localparam int IDX_W = $clog2(NODES);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state_q;
  logic [IDX_W-1:0]          wr_idx_q;
  logic [NODES*DATA_W-1:0]   frame_data_q, frame_data_d;
  logic                      frame_valid_q;
  logic                      in_ready_q;
  logic [4:0]                frame_len_q;
  logic [7:0]                frame_cnt_q;

  logic accept;
  logic last_beat;
  logic short_last;

  assign accept    = in_valid & in_ready_q;
  assign last_beat = (wr_idx_q == IDX_W'(NODES - 1));

`ifdef CUBE_LOADER_PAD_EN
  assign short_last = in_last & ~last_beat;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign short_last     = 1'b0;
`endif

  // Nodes past a short frame's last value become all-ones so they sort to the top.
  always_comb begin
    frame_data_d = frame_data_q;
    for (int k = 0; k < NODES; k++) begin
      if (k == int'(wr_idx_q)) begin
        frame_data_d[k*DATA_W +: DATA_W] = in_data;
      end else if (short_last && (k > int'(wr_idx_q))) begin
        frame_data_d[k*DATA_W +: DATA_W] = '1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      wr_idx_q      <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      in_ready_q    <= 1'b0;
      frame_len_q   <= 5'd0;
      frame_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        FILL: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            frame_data_q <= frame_data_d;
            if (last_beat || short_last) begin
              state_q       <= HOLD;
              frame_valid_q <= 1'b1;
              in_ready_q    <= 1'b0;
              frame_len_q   <= last_beat ? 5'(NODES) : 5'(wr_idx_q) + 5'd1;
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Upstream stays stalled through the handoff edge; refill starts a cycle later.
          if (frame_ready) begin
            state_q       <= FILL;
            frame_valid_q <= 1'b0;
            in_ready_q    <= 1'b1;
            wr_idx_q      <= '0;
            frame_cnt_q   <= frame_cnt_q + 8'd1;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign frame_len   = frame_len_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
